// File: rtl/vend_controller_if.sv
// Front-end / actuator signal bundle for vend_controller.
// The master modport is the coin acceptor/keypad/hopper side; the slave modport is the controller.
interface vend_controller_if #(
  parameter int NUM_ITEMS = 4,
  parameter int BAL_W     = 8,
  parameter int STOCK_W   = 4
);
  localparam int IDX_W = (NUM_ITEMS > 2) ? $clog2(NUM_ITEMS) : 1;

  logic                       coin_valid;
  logic [BAL_W-1:0]           coin_value;
  logic                       select;
  logic [IDX_W-1:0]           select_item;
  logic                       refund;
  logic [NUM_ITEMS*BAL_W-1:0] item_price;
  logic                       restock_valid;
  logic [IDX_W-1:0]           restock_item;
  logic [STOCK_W-1:0]         restock_qty;
  logic                       change_ack;

  logic [BAL_W-1:0]           balance;
  logic                       dispense;
  logic [IDX_W-1:0]           dispense_item;
  logic                       change_req;
  logic                       busy;
  logic                       coin_accept;
  logic                       coin_reject;
  logic                       invalid;
  logic                       insufficient;
  logic                       sold_out;
  logic                       refund_ack;
  logic [15:0]                sales_count;

  modport master (
    output coin_valid, coin_value, select, select_item, refund, item_price,
           restock_valid, restock_item, restock_qty, change_ack,
    input  balance, dispense, dispense_item, change_req, busy, coin_accept,
           coin_reject, invalid, insufficient, sold_out, refund_ack, sales_count
  );

  modport slave (
    input  coin_valid, coin_value, select, select_item, refund, item_price,
           restock_valid, restock_item, restock_qty, change_ack,
    output balance, dispense, dispense_item, change_req, busy, coin_accept,
           coin_reject, invalid, insufficient, sold_out, refund_ack, sales_count
  );
endinterface

// File: rtl/vend_controller.sv
// Multi-item vending controller: credit, per-item stock, vend and unit-by-unit change payout.
// Optional VEND_AUDIT_EN builds a saturating 16-bit sales counter; otherwise sales_count is 0.
//
// state    | meaning
// ---------+---------------------------------------------
// S_IDLE   | no credit, waiting for coin/select/restock
// S_CREDIT | credit held, accepting coins/select/refund
// S_VEND   | single-cycle dispense, decides on change
// S_PAYOUT | change_req high, one unit per change_ack
module vend_controller #(
  parameter int NUM_ITEMS   = 4,
  parameter int BAL_W       = 8,
  parameter int STOCK_W     = 4,
  parameter int MAX_BAL     = 95,
  parameter int COIN_A      = 5,
  parameter int COIN_B      = 10,
  parameter int COIN_C      = 25,
  parameter int CHANGE_UNIT = 5,
  parameter int STOCK_INIT  = 0
) (
  input logic              clk,
  input logic              reset,
  vend_controller_if.slave bus
);
  localparam int IDX_W = (NUM_ITEMS > 2) ? $clog2(NUM_ITEMS) : 1;

  localparam logic [BAL_W-1:0]   CA     = BAL_W'(COIN_A);
  localparam logic [BAL_W-1:0]   CB     = BAL_W'(COIN_B);
  localparam logic [BAL_W-1:0]   CC     = BAL_W'(COIN_C);
  localparam logic [BAL_W-1:0]   CU     = BAL_W'(CHANGE_UNIT);
  localparam logic [BAL_W:0]     MAX_X  = (BAL_W+1)'(MAX_BAL);
  localparam logic [STOCK_W-1:0] S_INIT = STOCK_W'(STOCK_INIT);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_PAYOUT} state_t;

  state_t             state_q;
  logic [BAL_W-1:0]   balance_q;
  logic               dispense_q;
  logic [IDX_W-1:0]   dispense_item_q;
  logic               change_req_q;
  logic               busy_q;
  logic               coin_accept_q;
  logic               coin_reject_q;
  logic               invalid_q;
  logic               insufficient_q;
  logic               sold_out_q;
  logic               refund_ack_q;
  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
`ifdef VEND_AUDIT_EN
  logic [15:0]        sales_q;
`endif

  logic [BAL_W-1:0]   price_sel;
  logic [STOCK_W-1:0] stock_sel;
  logic               item_ok;
  logic               coin_legal;
  logic               coin_fits;
  logic [BAL_W:0]     coin_sum;
  logic [BAL_W-1:0]   payout_rem;

  always_comb begin
    price_sel = '0;
    stock_sel = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (bus.select_item == IDX_W'(i)) begin
        price_sel = bus.item_price[i*BAL_W +: BAL_W];
        stock_sel = stock_q[i];
      end
    end
  end

  assign item_ok    = ({1'b0, bus.select_item} < (IDX_W+1)'(NUM_ITEMS));
  assign coin_legal = (bus.coin_value == CA) || (bus.coin_value == CB) || (bus.coin_value == CC);
  assign coin_sum   = {1'b0, balance_q} + {1'b0, bus.coin_value};
  assign coin_fits  = (coin_sum <= MAX_X);
  assign payout_rem = balance_q - CU;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      balance_q       <= '0;
      dispense_q      <= 1'b0;
      dispense_item_q <= '0;
      change_req_q    <= 1'b0;
      busy_q          <= 1'b0;
      coin_accept_q   <= 1'b0;
      coin_reject_q   <= 1'b0;
      invalid_q       <= 1'b0;
      insufficient_q  <= 1'b0;
      sold_out_q      <= 1'b0;
      refund_ack_q    <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= S_INIT;
`ifdef VEND_AUDIT_EN
      sales_q         <= '0;
`endif
    end else begin
      dispense_q     <= 1'b0;
      coin_accept_q  <= 1'b0;
      coin_reject_q  <= 1'b0;
      invalid_q      <= 1'b0;
      insufficient_q <= 1'b0;
      sold_out_q     <= 1'b0;
      refund_ack_q   <= 1'b0;

      case (state_q)
        S_IDLE, S_CREDIT: begin
          if (bus.refund && (balance_q != '0)) begin
            refund_ack_q <= 1'b1;
            if (bus.coin_valid) coin_reject_q <= 1'b1;
            // Credit below one hopper coin cannot be paid out, so it is forfeited here.
            if (balance_q >= CU) begin
              state_q      <= S_PAYOUT;
              change_req_q <= 1'b1;
              busy_q       <= 1'b1;
            end else begin
              balance_q <= '0;
              state_q   <= S_IDLE;
            end
          end else if (bus.select) begin
            if (bus.coin_valid) coin_reject_q <= 1'b1;
            if (!item_ok) begin
              invalid_q <= 1'b1;
            end else if (stock_sel == '0) begin
              sold_out_q <= 1'b1;
            end else if (balance_q < price_sel) begin
              insufficient_q <= 1'b1;
            end else begin
              balance_q       <= balance_q - price_sel;
              dispense_q      <= 1'b1;
              dispense_item_q <= bus.select_item;
              state_q         <= S_VEND;
              busy_q          <= 1'b1;
              for (int i = 0; i < NUM_ITEMS; i++) begin
                if (bus.select_item == IDX_W'(i)) stock_q[i] <= stock_sel - 1'b1;
              end
`ifdef VEND_AUDIT_EN
              if (sales_q != 16'hFFFF) sales_q <= sales_q + 16'd1;
`endif
            end
          end else if (bus.coin_valid) begin
            if (!coin_legal) begin
              invalid_q <= 1'b1;
            end else if (!coin_fits) begin
              coin_reject_q <= 1'b1;
            end else begin
              coin_accept_q <= 1'b1;
              balance_q     <= coin_sum[BAL_W-1:0];
              state_q       <= S_CREDIT;
            end
          end
        end

        S_VEND: begin
          if (bus.coin_valid) coin_reject_q <= 1'b1;
          if (balance_q >= CU) begin
            state_q      <= S_PAYOUT;
            change_req_q <= 1'b1;
          end else begin
            balance_q <= '0;
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
          end
        end

        S_PAYOUT: begin
          if (bus.coin_valid) coin_reject_q <= 1'b1;
          if (bus.change_ack) begin
            if (payout_rem < CU) begin
              balance_q    <= '0;
              change_req_q <= 1'b0;
              busy_q       <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              balance_q <= payout_rem;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase

      // Placed after the vend decrement so a same-item restock overrides it.
      if (bus.restock_valid) begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
          if (bus.restock_item == IDX_W'(i)) stock_q[i] <= bus.restock_qty;
        end
      end
    end
  end

  assign bus.balance       = balance_q;
  assign bus.dispense      = dispense_q;
  assign bus.dispense_item = dispense_item_q;
  assign bus.change_req    = change_req_q;
  assign bus.busy          = busy_q;
  assign bus.coin_accept   = coin_accept_q;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.invalid       = invalid_q;
  assign bus.insufficient  = insufficient_q;
  assign bus.sold_out      = sold_out_q;
  assign bus.refund_ack    = refund_ack_q;
`ifdef VEND_AUDIT_EN
  assign bus.sales_count   = sales_q;
`else
  assign bus.sales_count   = 16'd0;
`endif
endmodule

// File: tb/tb_vend_controller.sv
// Directed-vector bench for vend_controller with hand-computed expectations.
// Prices: item0 15, item1 20, item2 30, item3 40.
module tb_vend_controller;
  logic clk;
  logic reset;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   req_cycles;

`ifdef VEND_AUDIT_EN
  localparam int EXP_SALES = 3;
`else
  localparam int EXP_SALES = 0;
`endif

  vend_controller_if #(.NUM_ITEMS(4), .BAL_W(8), .STOCK_W(4)) bus ();

  vend_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.coin_valid    = 1'b0;
    bus.coin_value    = '0;
    bus.select        = 1'b0;
    bus.select_item   = '0;
    bus.refund        = 1'b0;
    bus.restock_valid = 1'b0;
    bus.restock_item  = '0;
    bus.restock_qty   = '0;
    bus.change_ack    = 1'b0;
  endtask

  task automatic coin(input logic [7:0] v);
    bus.coin_valid = 1'b1;
    bus.coin_value = v;
    tick();
    clr_in();
  endtask

  task automatic sel(input logic [1:0] item);
    bus.select      = 1'b1;
    bus.select_item = item;
    tick();
    clr_in();
  endtask

  task automatic restock(input logic [1:0] item, input logic [3:0] qty);
    bus.restock_valid = 1'b1;
    bus.restock_item  = item;
    bus.restock_qty   = qty;
    tick();
    clr_in();
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    bus.item_price = {8'd40, 8'd30, 8'd20, 8'd15};
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_balance", bus.balance, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_change_req", bus.change_req, 0);
    chk("rst_dispense", bus.dispense, 0);
    chk("rst_sales", bus.sales_count, 0);

    // Basic vend with exact credit
    restock(2'd0, 4'd3);
    coin(8'd10);
    chk("c10_accept", bus.coin_accept, 1);
    chk("c10_balance", bus.balance, 10);
    coin(8'd5);
    chk("c5_balance", bus.balance, 15);
    sel(2'd0);
    chk("v0_dispense", bus.dispense, 1);
    chk("v0_item", bus.dispense_item, 0);
    chk("v0_balance", bus.balance, 0);
    chk("v0_busy", bus.busy, 1);
    tick();
    chk("v0_no_change", bus.change_req, 0);
    chk("v0_idle_busy", bus.busy, 0);
    chk("v0_pulse_drop", bus.dispense, 0);

    // Vend with one unit of change, then sold out
    bus.restock_valid = 1'b1;
    bus.restock_item  = 2'd1;
    bus.restock_qty   = 4'd1;
    coin(8'd25);
    chk("c25_balance", bus.balance, 25);
    sel(2'd1);
    chk("v1_dispense", bus.dispense, 1);
    chk("v1_item", bus.dispense_item, 1);
    chk("v1_balance", bus.balance, 5);
    tick();
    chk("v1_change_req", bus.change_req, 1);
    bus.change_ack = 1'b1;
    tick();
    clr_in();
    chk("v1_req_drop", bus.change_req, 0);
    chk("v1_bal_zero", bus.balance, 0);
    chk("v1_busy_drop", bus.busy, 0);
    coin(8'd25);
    sel(2'd1);
    chk("v1_sold_out", bus.sold_out, 1);
    chk("v1_so_balance", bus.balance, 25);

    // Refund 35 with ack held high: seven units
    coin(8'd10);
    chk("c10b_balance", bus.balance, 35);
    bus.refund = 1'b1;
    tick();
    clr_in();
    chk("rf_ack", bus.refund_ack, 1);
    chk("rf_balance", bus.balance, 35);
    req_cycles = bus.change_req ? 1 : 0;
    bus.change_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.change_req) break;
      req_cycles++;
    end
    clr_in();
    chk("rf_req_cycles", req_cycles, 7);
    chk("rf_balance_end", bus.balance, 0);

    // Bad coin and ceiling overflow
    coin(8'd7);
    chk("c7_invalid", bus.invalid, 1);
    chk("c7_balance", bus.balance, 0);
    coin(8'd25); coin(8'd25); coin(8'd25); coin(8'd10); coin(8'd5);
    chk("c90_balance", bus.balance, 90);
    coin(8'd10);
    chk("ovf_reject", bus.coin_reject, 1);
    chk("ovf_accept", bus.coin_accept, 0);
    chk("ovf_balance", bus.balance, 90);

    // Coin colliding with a successful select
    restock(2'd2, 4'd2);
    bus.coin_valid = 1'b1;
    bus.coin_value = 8'd5;
    sel(2'd2);
    chk("cs_dispense", bus.dispense, 1);
    chk("cs_reject", bus.coin_reject, 1);
    chk("cs_accept", bus.coin_accept, 0);
    chk("cs_balance", bus.balance, 60);
    tick();
    chk("cs_change_req", bus.change_req, 1);
    coin(8'd25);
    chk("po_coin_reject", bus.coin_reject, 1);
    chk("po_balance", bus.balance, 60);
    bus.change_ack = 1'b1;
    repeat (9) tick();
    clr_in();
    chk("po_partial", bus.balance, 15);
    chk("po_still_req", bus.change_req, 1);
    chk("sales_pre_rst", bus.sales_count, EXP_SALES);

    // Asynchronous reset mid-payout
    reset = 1'b1;
    #2;
    chk("ar_change_req", bus.change_req, 0);
    chk("ar_balance", bus.balance, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_sales", bus.sales_count, 0);
    tick();
    reset = 1'b0;

    // Stock restored to 0 by reset; insufficient credit on a stocked item
    coin(8'd25);
    sel(2'd0);
    chk("post_sold_out", bus.sold_out, 1);
    restock(2'd3, 4'd1);
    sel(2'd3);
    chk("insufficient", bus.insufficient, 1);
    chk("ins_dispense", bus.dispense, 0);
    chk("ins_balance", bus.balance, 25);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
